// File: rtl/clk_div_pkg.sv
// Shared types and config sanitising for the programmable clock divider.
// The optional cfg_err output is enabled by defining CLKDIV_ERR_EN.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV = 2;
    localparam int unsigned CFG_W   = 32;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] hi;
        logic             clamped;
    } cfg_t;

    // The high-time clamp uses the already-clamped period.
    function automatic cfg_t sanitize(input logic [CFG_W-1:0] div, input logic [CFG_W-1:0] hi);
        cfg_t r;
        r.clamped = 1'b0;
        r.div     = div;
        r.hi      = hi;
        if (div < CFG_W'(MIN_DIV)) begin
            r.div     = CFG_W'(MIN_DIV);
            r.clamped = 1'b1;
        end
        if (hi == '0) begin
            r.hi      = 32'd1;
            r.clamped = 1'b1;
        end else if (hi >= r.div) begin
            r.hi      = r.div - 32'd1;
            r.clamped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Shadow configuration for prog_clk_divider: capture, pending flag, boundary forwarding,
// and the sticky cfg_err flag when CLKDIV_ERR_EN is defined.
module clk_div_shadow
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_cfg_load,
    input  logic [WIDTH-1:0] i_cfg_div,
    input  logic [WIDTH-1:0] i_cfg_hi,
    input  logic             i_boundary,
    output logic             o_pending,
    output logic             o_apply,
    output logic [WIDTH-1:0] o_div,
    output logic [WIDTH-1:0] o_hi
`ifdef CLKDIV_ERR_EN
    ,
    output logic             o_cfg_err
`endif
);

    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] DefHi  = WIDTH'(DEF_DIV / 2);

    cfg_t             w_san;
    logic [WIDTH-1:0] w_san_div;
    logic [WIDTH-1:0] w_san_hi;
    logic [WIDTH-1:0] r_sh_div;
    logic [WIDTH-1:0] r_sh_hi;
    logic             r_pending;
    logic             w_unused;

    assign w_san     = sanitize(CFG_W'(i_cfg_div), CFG_W'(i_cfg_hi));
    assign w_san_div = WIDTH'(w_san.div);
    assign w_san_hi  = WIDTH'(w_san.hi);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_div  <= DefDiv;
            r_sh_hi   <= DefHi;
            r_pending <= 1'b0;
        end else begin
            if (i_cfg_load) begin
                r_sh_div <= w_san_div;
                r_sh_hi  <= w_san_hi;
            end
            if (i_boundary) begin
                r_pending <= 1'b0;
            end else if (i_cfg_load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // A load coinciding with a boundary bypasses the shadow and lands immediately.
    assign o_apply   = i_boundary & (r_pending | i_cfg_load);
    assign o_div     = i_cfg_load ? w_san_div : r_sh_div;
    assign o_hi      = i_cfg_load ? w_san_hi  : r_sh_hi;
    assign o_pending = r_pending;

`ifdef CLKDIV_ERR_EN
    logic r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_cfg_load) begin
            if (w_san.clamped) begin
                r_err <= 1'b1;
            end else if (!i_en) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_cfg_err = r_err;
    assign w_unused  = ^{w_san.div, w_san.hi};
`else
    assign w_unused  = ^w_san;
`endif

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with high-time control and shadowed config.
// Defining CLKDIV_ERR_EN adds the sticky cfg_err output.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_hi,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
`ifdef CLKDIV_ERR_EN
    output logic             cfg_err,
`endif
    output logic             cfg_pending
);

    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] DefHi  = WIDTH'(DEF_DIV / 2);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_d;
    logic [WIDTH-1:0] r_act_div;
    logic [WIDTH-1:0] r_act_hi;
    logic             w_boundary;
    logic             w_apply;
    logic [WIDTH-1:0] w_new_div;
    logic [WIDTH-1:0] w_new_hi;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_busy;

    clk_div_shadow #(
        .WIDTH   (WIDTH),
        .DEF_DIV (DEF_DIV)
    ) u_shadow (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_cfg_load (cfg_load),
        .i_cfg_div  (cfg_div),
        .i_cfg_hi   (cfg_hi),
        .i_boundary (w_boundary),
        .o_pending  (cfg_pending),
        .o_apply    (w_apply),
        .o_div      (w_new_div),
        .o_hi       (w_new_hi)
`ifdef CLKDIV_ERR_EN
        ,
        .o_cfg_err  (cfg_err)
`endif
    );

    always_comb begin
        w_state_d  = r_state;
        w_count_d  = r_count;
        w_boundary = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_d  = HIGH;
                    w_count_d  = '0;
                    w_boundary = 1'b1;
                end
            end
            HIGH: begin
                w_count_d = r_count + One;
                if (r_count == r_act_hi - One) begin
                    w_state_d = LOW;
                end
            end
            LOW: begin
                if (r_count == r_act_div - One) begin
                    w_count_d = '0;
                    if (en) begin
                        w_state_d  = HIGH;
                        w_boundary = 1'b1;
                    end else begin
                        w_state_d = IDLE;
                    end
                end else begin
                    w_count_d = r_count + One;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_count_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change exactly with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_act_div <= DefDiv;
            r_act_hi  <= DefHi;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_count   <= w_count_d;
            if (w_apply) begin
                r_act_div <= w_new_div;
                r_act_hi  <= w_new_hi;
            end
            r_clk_out <= (w_state_d == HIGH);
            r_tick    <= (w_state_d == HIGH) && (r_state != HIGH);
            r_busy    <= (w_state_d != IDLE);
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign busy    = r_busy;

endmodule
